bin_sseg_scan: RTL and testbench



---
 rtl/bin_sseg_scan.sv | 184 ++++++++++++++++++
 tb/tb_bin_sseg_scan.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bin_sseg_scan.sv
// Binary to decimal seven-segment scanner: sequential double-dabble conversion feeding a
// time-multiplexed common-anode display. Define SSEG_LZB_EN to blank leading zero digits.
module bin_sseg_scan #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned CLK_DIV  = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    num,
  output logic [0:6]          sseg,
  output logic [N_DIGITS-1:0] an,
  output logic                led,
  output logic                busy
);

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  localparam int unsigned BCD_N  = (WIDTH * 302 + 999) / 1000 + 1;
  localparam int unsigned SCR_N  = (BCD_N > N_DIGITS) ? BCD_N : N_DIGITS;
  localparam int unsigned SCR_W  = 4 * SCR_N;
  localparam int unsigned DISP_W = 4 * N_DIGITS;
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned PRE_W  = $clog2(CLK_DIV);
  localparam int unsigned IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [63:0] LIMIT  = pow10(N_DIGITS) - 64'd1;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_last;
  logic [WIDTH-1:0]   r_sr;
  logic [SCR_W-1:0]   r_bcd;
  logic [SCR_W-1:0]   w_adj;
  logic [CNT_W-1:0]   r_cnt;
  logic [DISP_W-1:0]  r_disp;
  logic               r_led;
  logic               w_start;

  logic [PRE_W-1:0]   r_pre;
  logic [IDX_W-1:0]   r_idx;
  logic               r_run;
  logic               w_tick;
  logic [31:0]        w_idx;
  logic [3:0]         w_nib;
  logic               w_blank;
  logic [6:0]         w_seg;
  logic [N_DIGITS-1:0] w_an;

  assign w_start = (r_state == S_IDLE) && (num != r_last);
  assign busy    = (r_state != S_IDLE);
  assign led     = r_led;

  // ---------------- conversion FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_SHIFT;
      S_SHIFT: if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_adj = r_bcd;
    for (int unsigned i = 0; i < SCR_N; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last <= '0;
      r_sr   <= '0;
      r_bcd  <= '0;
      r_cnt  <= '0;
      r_disp <= '0;
      r_led  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_sr   <= num;
            r_last <= num;
            r_bcd  <= '0;
            r_cnt  <= '0;
          end
        end
        S_SHIFT: begin
          r_bcd <= {w_adj[SCR_W-2:0], r_sr[WIDTH-1]};
          r_sr  <= r_sr << 1;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DONE: begin
          // Display and overflow flag update together so a scan never shows a mixed value.
          r_disp <= r_bcd[DISP_W-1:0];
          r_led  <= (64'(r_last) > LIMIT);
        end
        default: ;
      endcase
    end
  end

  // ---------------- digit scan ----------------
  assign w_tick = (r_pre == PRE_W'(CLK_DIV - 1));

  // The first tick after reset only enables the outputs, so scanning starts on digit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
      r_idx <= '0;
      r_run <= 1'b0;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick) begin
        if (!r_run)                                r_run <= 1'b1;
        else if (r_idx == IDX_W'(N_DIGITS - 1))    r_idx <= '0;
        else                                       r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign w_idx = 32'(r_idx);
  assign w_nib = r_disp[4*w_idx +: 4];
  assign w_an  = ~(N_DIGITS'(1) << r_idx);

`ifdef SSEG_LZB_EN
  always_comb begin
    logic w_upper_nz;
    w_upper_nz = 1'b0;
    for (int unsigned j = 0; j < N_DIGITS; j++) begin
      if (j >= w_idx && r_disp[4*j +: 4] != 4'd0) w_upper_nz = 1'b1;
    end
    w_blank = (w_idx != 32'd0) && !w_upper_nz;
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    w_seg = seg7(w_nib);
    if (r_led)        w_seg = 7'b1111110;
    else if (w_blank) w_seg = 7'b1111111;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sseg <= '1;
      an   <= '1;
    end else if (r_run) begin
      sseg <= w_seg;
      an   <= w_an;
    end
  end

endmodule

// File: tb/tb_bin_sseg_scan.sv
// Randomized self-checking bench for bin_sseg_scan: two instances (4 digits and 2 digits)
// compared against a decimal arithmetic model of what each scanned digit must show.
module tb_bin_sseg_scan;

  localparam int unsigned W  = 8;
  localparam int unsigned NA = 4;
  localparam int unsigned DA = 4;
  localparam int unsigned NB = 2;
  localparam int unsigned DB = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [W-1:0]  num_a = '0;
  logic [W-1:0]  num_b = '0;
  logic [0:6]    sseg_a, sseg_b;
  logic [NA-1:0] an_a;
  logic [NB-1:0] an_b;
  logic          led_a, led_b, busy_a, busy_b;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  bin_sseg_scan #(.WIDTH(W), .N_DIGITS(NA), .CLK_DIV(DA)) dut_a (
    .clk(clk), .rst(rst), .num(num_a), .sseg(sseg_a), .an(an_a), .led(led_a), .busy(busy_a)
  );

  bin_sseg_scan #(.WIDTH(W), .N_DIGITS(NB), .CLK_DIV(DB)) dut_b (
    .clk(clk), .rst(rst), .num(num_b), .sseg(sseg_b), .an(an_b), .led(led_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned p10(input int unsigned n);
    int unsigned r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] dig_seg(input int unsigned d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Pattern a digit position must show for a displayed value on an nd-digit display.
  function automatic logic [6:0] exp_seg(input int unsigned val, input int unsigned idx,
                                         input int unsigned nd);
    if (val > p10(nd) - 1) return 7'b1111110;
`ifdef SSEG_LZB_EN
    if (idx != 0 && val < p10(idx)) return 7'b1111111;
`endif
    return dig_seg((val / p10(idx)) % 10);
  endfunction

  function automatic int idx_of(input logic [7:0] an_v, input int unsigned nd);
    int pos = -1;
    int zeros = 0;
    for (int i = 0; i < int'(nd); i++) begin
      if (!an_v[i]) begin
        zeros++;
        pos = i;
      end
    end
    return (zeros == 1) ? pos : -1;
  endfunction

  task automatic scan_check(input bit b, input int unsigned val, input int unsigned cycles);
    int          i;
    int unsigned nd;
    logic [6:0]  sg;
    for (int unsigned c = 0; c < cycles; c++) begin
      @(negedge clk);
      nd = b ? NB : NA;
      sg = b ? sseg_b : sseg_a;
      i  = b ? idx_of(8'(an_b), NB) : idx_of(8'(an_a), NA);
      check(b ? "an1hot_b" : "an1hot_a", 32'(i >= 0), 32'd1);
      if (i >= 0) check(b ? "seg_b" : "seg_a", 32'(sg), 32'(exp_seg(val, i, nd)));
      check(b ? "led_b" : "led_a", 32'(b ? led_b : led_a), 32'(val > p10(nd) - 1));
    end
  endtask

  // Busy must span exactly W+1 cycles; sseg switches from old to new value one cycle after.
  task automatic conv_watch(input int unsigned oldv, input int unsigned newv);
    int nb = 0;
    int fall = 0;
    int i;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (busy_a) nb++;
      else if (fall == 0 && nb > 0) fall = k;
      i = idx_of(8'(an_a), NA);
      if (k == 10 && i >= 0) check("seg_old", 32'(sseg_a), 32'(exp_seg(oldv, i, NA)));
      if (k == 11 && i >= 0) check("seg_new", 32'(sseg_a), 32'(exp_seg(newv, i, NA)));
    end
    check("busy_len", nb, W + 1);
    check("busy_fall", fall, W + 2);
  endtask

  logic [3:0] scan_seq [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
  int unsigned b_vals [6] = '{100, 99, 0, 255, 9, 10};

  initial begin
    int          n;
    int          i;
    int unsigned cur;
    int unsigned v;
    logic [NA-1:0] prev;

    // Reset held: outputs idle whatever num and clk do.
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      num_a = W'($urandom);
      num_b = W'($urandom);
      #1;
      check("rst_sseg", 32'(sseg_a), 32'h7f);
      check("rst_an", 32'(an_a), 32'hf);
      check("rst_led", 32'(led_a), 32'd0);
      check("rst_busy", 32'(busy_a | busy_b), 32'd0);
    end
    @(negedge clk);
    num_a = '0;
    num_b = '0;
    rst   = 1'b1;

    n = 0;
    do begin @(negedge clk); n++; end while (an_a == '1 && n < 20);
    check("first_tick", n, DA + 1);
    check("an_first", 32'(an_a), 32'b1110);
    check("seg_first", 32'(sseg_a), 32'(exp_seg(0, 0, NA)));
    check("busy_idle", 32'(busy_a), 32'd0);

    for (int s = 0; s < 4; s++) begin
      prev = an_a;
      n = 0;
      do begin @(negedge clk); n++; end while (an_a == prev && n < 20);
      check("scan_gap", n, DA);
      check("scan_an", 32'(an_a), 32'(scan_seq[s]));
      check("scan_seg", 32'(sseg_a), 32'(exp_seg(0, (s + 1) % 4, NA)));
    end

    // 255 on four digits.
    @(negedge clk);
    num_a = 8'd255;
    conv_watch(0, 255);
    scan_check(1'b0, 255, 2 * NA * DA);
    cur = 255;

    // num changes mid-conversion: 12 is shown first, then 200 wins.
    @(negedge clk);
    num_a = 8'd12;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 3) num_a = 8'd200;
      i = idx_of(8'(an_a), NA);
      if (k == 9)  check("mid_busy9", 32'(busy_a), 32'd1);
      if (k == 10) check("mid_gap", 32'(busy_a), 32'd0);
      if (k == 11) check("mid_refire", 32'(busy_a), 32'd1);
      if (k == 19) check("mid_busy19", 32'(busy_a), 32'd1);
      if (k == 20) check("mid_done", 32'(busy_a), 32'd0);
      if (i >= 0) begin
        if (k == 10)                check("mid_seg255", 32'(sseg_a), 32'(exp_seg(255, i, NA)));
        else if (k >= 11 && k <= 20) check("mid_seg12", 32'(sseg_a), 32'(exp_seg(12, i, NA)));
        else if (k >= 21)           check("mid_seg200", 32'(sseg_a), 32'(exp_seg(200, i, NA)));
      end
    end
    cur = 200;
    scan_check(1'b0, 200, NA * DA);

    // Random values.
    for (int r = 0; r < 8; r++) begin
      v = $urandom_range(0, 255);
      if (v == cur) v = (v + 1) % 256;
      @(negedge clk);
      num_a = W'(v);
      conv_watch(cur, v);
      scan_check(1'b0, v, NA * DA + 2);
      cur = v;
    end

    // Reset during SHIFT, then reconversion of the unchanged input.
    v = (cur == 77) ? 78 : 77;
    @(negedge clk);
    num_a = W'(v);
    repeat (4) @(negedge clk);
    check("pre_rst_busy", 32'(busy_a), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    check("mid_rst_an", 32'(an_a), 32'hf);
    check("mid_rst_sseg", 32'(sseg_a), 32'h7f);
    check("mid_rst_led", 32'(led_a), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      i = idx_of(8'(an_a), NA);
      if (k == 1)  check("reconv_busy", 32'(busy_a), 32'd1);
      if (k == 4)  check("rst_blank_an", 32'(an_a), 32'hf);
      if (k == 10) check("reconv_done", 32'(busy_a), 32'd0);
      if (k >= 5 && k <= 10 && i >= 0) check("rst_disp0", 32'(sseg_a), 32'(exp_seg(0, i, NA)));
      if (k >= 11 && i >= 0)           check("reconv_seg", 32'(sseg_a), 32'(exp_seg(v, i, NA)));
    end
    scan_check(1'b0, v, NA * DA);

    // Two-digit instance: overflow boundary and a few other values.
    for (int r = 0; r < 9; r++) begin
      v = (r < 6) ? b_vals[r] : $urandom_range(0, 255);
      @(negedge clk);
      num_b = W'(v);
      repeat (W + 3) @(negedge clk);
      check("b_idle", 32'(busy_b), 32'd0);
      scan_check(1'b1, v, NB * DB + 2);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
